// File: rtl/serial_io_ctrl_pkg.sv
// Shared encodings for the serial pin front end: host mode select, controller
// states and the RegFile geometry.
package serial_io_ctrl_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 10;
   localparam int CNT_W  = 7;

   typedef enum logic [1:0] {
      MODE_IDLE = 2'b00,
      MODE_DIN  = 2'b01,
      MODE_ADDR = 2'b10,
      MODE_DOUT = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_WRITE   = 2'b01,
      ST_RD_WAIT = 2'b10,
      ST_OUT     = 2'b11
   } state_e;

   function automatic mode_e decode_mode(input logic lad1, input logic lad2);
      return mode_e'({lad1, lad2});
   endfunction

   // Where a fresh host request leads; a busy core turns it into a refusal.
   function automatic state_e decode_req(input logic busy, input logic wr);
      state_e nxt;
      if (busy) begin
         nxt = ST_IDLE;
      end else if (wr) begin
         nxt = ST_WRITE;
      end else begin
         nxt = ST_RD_WAIT;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/serial_io_ctrl_shift_reg.sv
// Right-shifting register with serial input at the MSB, parallel load and
// synchronous active-low clear; used for data in, address and data out.
module sio_shift_reg
   import serial_io_ctrl_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         shift_en,
   input  logic         load_en,
   input  logic         ser_in,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] q
);

   // clear, then parallel load, then shift; otherwise hold
   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= {W{1'b0}};
      end else if (load_en) begin
         q <= load_val;
      end else if (shift_en) begin
         q <= {ser_in, q[W-1:1]};
      end
   end

endmodule

// File: rtl/serial_io_ctrl.sv
// Pin-side front end: deserialises host words/addresses into RegFile writes
// and serialises RegFile read data back out on dout.
module serial_io_ctrl #(
   parameter int DATA_W = serial_io_ctrl_pkg::DATA_W,
   parameter int ADDR_W = serial_io_ctrl_pkg::ADDR_W,
   parameter int CNT_W  = serial_io_ctrl_pkg::CNT_W
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              LAD1,
   input  logic              LAD2,
   input  logic              din,
   input  logic              addr,
   input  logic              we,
   input  logic              addr_ready,
   input  logic              core_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic              dout,
   output logic              err
);

   import serial_io_ctrl_pkg::*;

   mode_e             mode_s;
   state_e            state_r;
   state_e            state_nxt_s;
   logic              ar_q_r;
   logic              req_s;
   logic              decode_s;
   logic              start_wr_s;
   logic              start_rd_s;
   logic              err_set_s;
   logic              out_load_s;
   logic              out_shift_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic [DATA_W-1:0] din_sreg_r;
   logic [ADDR_W-1:0] addr_sreg_r;
   logic [DATA_W-1:0] out_sreg_r;

   assign mode_s = decode_mode(LAD1, LAD2);
   assign req_s  = addr_ready & ~ar_q_r;

   // A request is decoded from IDLE, or from OUT where it abandons the remaining bits.
   assign decode_s   = req_s & ((state_r == ST_IDLE) | (state_r == ST_OUT));
   assign start_wr_s = decode_s & ~core_busy & we;
   assign start_rd_s = decode_s & ~core_busy & ~we;
   assign err_set_s  = decode_s & core_busy;

   assign dout = out_sreg_r[0];

   sio_shift_reg #(.W(DATA_W)) u_din_sreg (
      .clk      (clk1),
      .rst      (rst),
      .shift_en (mode_s == MODE_DIN),
      .load_en  (1'b0),
      .ser_in   (din),
      .load_val ({DATA_W{1'b0}}),
      .q        (din_sreg_r)
   );

   sio_shift_reg #(.W(ADDR_W)) u_addr_sreg (
      .clk      (clk1),
      .rst      (rst),
      .shift_en (mode_s == MODE_ADDR),
      .load_en  (1'b0),
      .ser_in   (addr),
      .load_val ({ADDR_W{1'b0}}),
      .q        (addr_sreg_r)
   );

   sio_shift_reg #(.W(DATA_W)) u_out_sreg (
      .clk      (clk1),
      .rst      (rst),
      .shift_en (out_shift_s),
      .load_en  (out_load_s),
      .ser_in   (1'b0),
      .load_val (mem_rdata),
      .q        (out_sreg_r)
   );

   // next-state, read-data load and output shift control
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      out_load_s  = 1'b0;
      out_shift_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_s) begin
               state_nxt_s = decode_req(core_busy, we);
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            state_nxt_s = ST_IDLE;
         end
         ST_RD_WAIT: begin
            if (mem_rvalid) begin
               out_load_s  = 1'b1;
               cnt_nxt_s   = CNT_W'(DATA_W);
               state_nxt_s = ST_OUT;
            end else begin
               state_nxt_s = ST_RD_WAIT;
            end
         end
         ST_OUT: begin
            if (req_s) begin
               state_nxt_s = decode_req(core_busy, we);
            end else if (cnt_r == {CNT_W{1'b0}}) begin
               state_nxt_s = ST_IDLE;
            end else if (mode_s == MODE_DOUT) begin
               out_shift_s = 1'b1;
               cnt_nxt_s   = cnt_r - CNT_W'(1);
            end else begin
               state_nxt_s = ST_OUT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // controller state, request edge history and output bit counter
   always_ff @(posedge clk1) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         ar_q_r  <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         ar_q_r  <= addr_ready;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // RegFile port (address/data frozen at the request edge) and sticky refusal flag
   always_ff @(posedge clk1) begin
      if (!rst) begin
         mem_addr  <= {ADDR_W{1'b0}};
         mem_wdata <= {DATA_W{1'b0}};
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_we <= start_wr_s;
         mem_re <= start_rd_s;
         err    <= err | err_set_s;
         if (start_wr_s | start_rd_s) begin
            mem_addr <= addr_sreg_r;
         end
         if (start_wr_s) begin
            mem_wdata <= din_sreg_r;
         end
      end
   end

endmodule

// File: tb/tb_serial_io_ctrl.sv
// Self-checking bench for serial_io_ctrl: directed scenarios plus a randomized
// transaction loop, checked against a sample-history model of the pin protocol.
module tb_serial_io_ctrl;

   logic        clk1 = 1'b0;
   logic        rst = 1'b0;
   logic        LAD1 = 1'b0;
   logic        LAD2 = 1'b0;
   logic        din = 1'b0;
   logic        addr = 1'b0;
   logic        we = 1'b0;
   logic        addr_ready = 1'b0;
   logic        core_busy = 1'b0;
   logic [63:0] mem_rdata = 64'd0;
   logic        mem_rvalid = 1'b0;
   logic [9:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic        dout;
   logic        err;

   int          n_checks = 0;
   int          n_fail = 0;
   int          we_cnt = 0;
   int          re_cnt = 0;
   logic [9:0]  we_addr = 10'd0;
   logic [63:0] we_data = 64'd0;
   bit          exp_err = 1'b0;
   bit          din_hist[$];
   bit          addr_hist[$];

   serial_io_ctrl dut (
      .clk1       (clk1),
      .rst        (rst),
      .LAD1       (LAD1),
      .LAD2       (LAD2),
      .din        (din),
      .addr       (addr),
      .we         (we),
      .addr_ready (addr_ready),
      .core_busy  (core_busy),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .dout       (dout),
      .err        (err)
   );

   always #5 clk1 = ~clk1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Word the host has sent: the last 64 mode-01 samples, oldest at bit 0.
   function automatic logic [63:0] model_word();
      logic [63:0] w;
      int n;
      int idx;
      w = 64'd0;
      n = din_hist.size();
      for (int j = 0; j < 64; j++) begin
         idx = n - 64 + j;
         if (idx >= 0) w[j] = din_hist[idx];
      end
      return w;
   endfunction

   function automatic logic [9:0] model_addr();
      logic [9:0] a;
      int n;
      int idx;
      a = 10'd0;
      n = addr_hist.size();
      for (int j = 0; j < 10; j++) begin
         idx = n - 10 + j;
         if (idx >= 0) a[j] = addr_hist[idx];
      end
      return a;
   endfunction

   // One clock: record what the pins present at this edge, then observe after it.
   task automatic step();
      if (!rst) begin
         din_hist.delete();
         addr_hist.delete();
      end else if (LAD1 == 1'b0 && LAD2 == 1'b1) begin
         din_hist.push_back(din);
         if (din_hist.size() > 64) void'(din_hist.pop_front());
      end else if (LAD1 == 1'b1 && LAD2 == 1'b0) begin
         addr_hist.push_back(addr);
         if (addr_hist.size() > 10) void'(addr_hist.pop_front());
      end
      @(posedge clk1);
      #1;
      if (mem_we === 1'b1) begin
         we_cnt++;
         we_addr = mem_addr;
         we_data = mem_wdata;
      end
      if (mem_re === 1'b1) re_cnt++;
   endtask

   task automatic set_mode(input logic [1:0] m);
      {LAD1, LAD2} = m;
   endtask

   task automatic shift_data(input logic [63:0] w, input int stale);
      set_mode(2'b01);
      repeat (stale) begin
         din = 1'($urandom_range(0, 1));
         step();
      end
      for (int j = 0; j < 64; j++) begin
         din = w[j];
         step();
      end
      set_mode(2'b00);
      din = 1'($urandom_range(0, 1));
      step();
   endtask

   task automatic shift_addr(input logic [9:0] a, input int stale);
      set_mode(2'b10);
      repeat (stale) begin
         addr = 1'($urandom_range(0, 1));
         step();
      end
      for (int j = 0; j < 10; j++) begin
         addr = a[j];
         step();
      end
      set_mode(2'b00);
      addr = 1'($urandom_range(0, 1));
      step();
   endtask

   // Write request (or any refused request when busy); addr_ready held for 'hold' cycles.
   task automatic host_req(input logic we_v, input logic busy, input int hold);
      int w0;
      int r0;
      logic [9:0]  ea;
      logic [63:0] ed;
      w0 = we_cnt;
      r0 = re_cnt;
      ea = model_addr();
      ed = model_word();
      we = we_v;
      core_busy = busy;
      addr_ready = 1'b1;
      step();
      core_busy = 1'b0;
      repeat (hold - 1) step();
      addr_ready = 1'b0;
      we = 1'b0;
      step();
      step();
      if (busy) exp_err = 1'b1;
      check_val("wr_strobe_count", 64'(we_cnt - w0), busy ? 64'd0 : 64'd1);
      check_val("wr_no_read", 64'(re_cnt - r0), 64'd0);
      if (!busy) begin
         check_val("wr_addr", 64'(we_addr), 64'(ea));
         check_val("wr_data", we_data, ed);
      end
      check_val("err_flag", 64'(err), 64'(exp_err));
   endtask

   // Read at the current address; memory answers after 'lat' cycles; collect nbits of dout.
   task automatic do_read(input logic [63:0] word, input int lat, input int nbits);
      int r0;
      int w0;
      logic [9:0]  ea;
      logic [63:0] got;
      logic [63:0] mask;
      logic        tail;
      r0 = re_cnt;
      w0 = we_cnt;
      ea = model_addr();
      got = 64'd0;
      tail = 1'b0;
      we = 1'b0;
      addr_ready = 1'b1;
      step();
      addr_ready = 1'b0;
      check_val("rd_re_pulse", 64'(mem_re), 64'd1);
      check_val("rd_addr", 64'(mem_addr), 64'(ea));
      set_mode(2'b11);
      repeat (lat) step();
      mem_rdata = word;
      mem_rvalid = 1'b1;
      step();
      mem_rvalid = 1'b0;
      mem_rdata = {$urandom, $urandom};
      for (int i = 0; i < nbits; i++) begin
         got[i] = dout;
         step();
      end
      mask = (nbits >= 64) ? {64{1'b1}} : ((64'd1 << nbits) - 64'd1);
      check_val("rd_dout_bits", got & mask, word & mask);
      if (nbits >= 64) begin
         repeat (3) begin
            tail = tail | dout;
            step();
         end
         check_val("rd_dout_tail", 64'(tail), 64'd0);
         set_mode(2'b00);
         step();
      end
      check_val("rd_re_once", 64'(re_cnt - r0), 64'd1);
      check_val("rd_no_write", 64'(we_cnt - w0), 64'd0);
   endtask

   initial begin
      logic [63:0] rw;
      logic [9:0]  ra;
      int          kind;
      int          r0;

      // reset state
      rst = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      check_val("rst_ctrl", 64'({mem_we, mem_re, err, dout}), 64'd0);
      check_val("rst_addr", 64'(mem_addr), 64'd0);
      check_val("rst_wdata", mem_wdata, 64'd0);

      // basic write to address 0
      shift_data(64'h5e8c154d23501506, 0);
      shift_addr(10'd0, 0);
      host_req(1'b1, 1'b0, 1);
      check_val("wr0_data_const", we_data, 64'h5e8c154d23501506);

      // address 768 with a stale leading sample, addr_ready held 5 cycles
      shift_data(64'hc4105f43f504f0b2, 2);
      shift_addr(10'd768, 1);
      host_req(1'b1, 1'b0, 5);
      check_val("wr768_addr_const", 64'(we_addr), 64'h300);
      check_val("wr768_data_const", we_data, 64'hc4105f43f504f0b2);

      // read at 776, latency 3, full read-out
      shift_addr(10'd776, 0);
      do_read(64'h9bfd7a44481145cd, 3, 64);

      // busy refusal, then a legal write with err still set
      shift_data(64'h0123456789abcdef, 0);
      host_req(1'b1, 1'b1, 1);
      shift_addr(10'd33, 0);
      host_req(1'b1, 1'b0, 1);

      // reset while waiting for read data; late rvalid must be ignored
      shift_addr(10'd513, 0);
      r0 = re_cnt;
      we = 1'b0;
      addr_ready = 1'b1;
      step();
      addr_ready = 1'b0;
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      exp_err = 1'b0;
      mem_rdata = 64'hffffffffffffffff;
      mem_rvalid = 1'b1;
      step();
      mem_rvalid = 1'b0;
      set_mode(2'b11);
      step();
      step();
      check_val("rstrd_ctrl", 64'({mem_we, mem_re, err, dout}), 64'd0);
      check_val("rstrd_addr", 64'(mem_addr), 64'd0);
      check_val("rstrd_wdata", mem_wdata, 64'd0);
      check_val("rstrd_re_count", 64'(re_cnt - r0), 64'd1);
      set_mode(2'b00);
      step();
      // data register was cleared: an address-only write carries zero data
      shift_addr(10'h2a5, 0);
      host_req(1'b1, 1'b0, 1);

      // preemption after 20 bits by a read at address 5
      shift_addr(10'd300, 0);
      do_read(64'hdeadbeefcafef00d, 2, 20);
      shift_addr(10'd5, 0);
      do_read(64'h13579bdf2468ace0, 1, 64);

      // randomized transactions
      for (int t = 0; t < 24; t++) begin
         kind = $urandom_range(0, 3);
         rw = {$urandom, $urandom};
         ra = 10'($urandom_range(0, 1023));
         case (kind)
            0, 1: begin
               if ($urandom_range(0, 3) != 0) shift_data(rw, $urandom_range(0, 3));
               shift_addr(ra, $urandom_range(0, 3));
               host_req(1'b1, 1'b0, $urandom_range(1, 4));
            end
            2: begin
               shift_addr(ra, $urandom_range(0, 3));
               do_read(rw, $urandom_range(1, 3), 64);
            end
            default: begin
               shift_addr(ra, 0);
               host_req(1'($urandom_range(0, 1)), 1'b1, 1);
            end
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_io_ctrl.md
Name: serial_io_ctrl

Overview:
- Chip-side pin front end that sits directly behind the pad ring and in front of the core RegFile.
- Deserialises the bit-serial pin protocol (LAD1/LAD2 mode select, din, addr) into 64-bit word writes at 10-bit addresses.
- Serialises RegFile read data back out on dout.
- Feeds the compute core's memory port during load/unload phases; never drives it while the core is busy.

Parameters:
DATA_W, 64, RegFile word width
ADDR_W, 10, RegFile address width
CNT_W, 7, width of output bit counter (must hold DATA_W)

Ports:
clk1  in  1  system clock
rst  in  1  synchronous reset, active-low
LAD1  in  1  mode select bit 1
LAD2  in  1  mode select bit 0
din  in  1  serial data in
addr  in  1  serial address in
we  in  1  write request qualifier
addr_ready  in  1  transfer request strobe (level; rising edge acts)
core_busy  in  1  core owns RegFile; host accesses are refused
mem_addr  out  ADDR_W  RegFile address
mem_wdata  out  DATA_W  RegFile write data
mem_we  out  1  single-cycle write strobe
mem_re  out  1  single-cycle read strobe
mem_rdata  in  DATA_W  RegFile read data
mem_rvalid  in  1  read data valid; variable latency ≥1 cycle after mem_re
dout  out  1  serial data out
err  out  1  sticky: access refused because core_busy

Behaviour:
- Mode = {LAD1,LAD2}. 00 idle; 01 shift data; 10 shift address; 11 shift out.
- Mode 01: each clk1 rising edge, din_sreg <= {din, din_sreg[DATA_W-1:1]}. The last DATA_W samples are retained, so bit j of the word equals the j-th bit sent (LSB first). Extra leading samples from a stale din fall off the bottom.
- Mode 10: addr_sreg <= {addr, addr_sreg[ADDR_W-1:1]} under the same rule.
- Other modes hold din_sreg and addr_sreg.
- Request edge: ar_q is registered addr_ready; req = addr_ready & ~ar_q. A held level never re-triggers.
- FSM states: IDLE, WRITE, RD_WAIT, OUT.
- IDLE, req & core_busy: no memory strobe; err <= 1; stay in IDLE.
- IDLE, req & we & ~core_busy: go to WRITE. Capture mem_addr <= addr_sreg and mem_wdata <= din_sreg at the req edge.
- WRITE: mem_we=1 for exactly one cycle, then IDLE.
- IDLE, req & ~we & ~core_busy: mem_addr <= addr_sreg, mem_re=1 for one cycle, go to RD_WAIT.
- RD_WAIT: on mem_rvalid, out_sreg <= mem_rdata, cnt <= DATA_W, go to OUT. There is no timeout.
- OUT: each cycle with mode 11 and cnt≠0, out_sreg shifts right (zero fill) and cnt decrements. Mode ≠11 holds. cnt==0 → IDLE.
- OUT, req: a new request preempts. Remaining bits are abandoned and the request is decoded as from IDLE.
- dout = out_sreg[0] combinationally. First bit is valid on the cycle OUT is entered; dout=0 once drained.
- mem_rvalid outside RD_WAIT is ignored.
- Shifting during WRITE/RD_WAIT is allowed. Captured values are fixed at the req edge.
- Reset (rst=0, sync): all of the following clear to 0 at the next edge, including mid-shift or mid-read; state <= IDLE.
  - din_sreg, addr_sreg, out_sreg, cnt, ar_q
  - mem_addr, mem_wdata, mem_we, mem_re, err
- err clears only on reset.
- Host timing contract: ≥65 mode-01 cycles per word, ≥11 mode-10 cycles per address, ≥1 idle cycle before req. The read-out budget is the 67 mode-11 cycles hosts already use: memory latency ≤3.

Decomposition:
- Shared package holds:
  - mode encodings MODE_IDLE=2'b00, MODE_DIN=2'b01, MODE_ADDR=2'b10, MODE_DOUT=2'b11
  - FSM state typedef
  - DATA_W and ADDR_W constants
- One natural sub-module, sio_shift_reg: parameterised width, right shift with serial-in at MSB, parallel load, zero fill. It is instantiated three times: data in, address, data out.

Test Plan:
- Write: serialise 64'h5e8c154d23501506 then address 0, pulse we+addr_ready → exactly one mem_we cycle, mem_addr=0, mem_wdata=64'h5e8c154d23501506.
- Address 768: shift 10'd768 with one stale leading sample, then write 64'hc4105f43f504f0b2 → mem_addr=10'h300, correct data. Holding addr_ready high 5 cycles still yields a single strobe.
- Read: address 776, req with we=0, memory returns 64'h9bfd7a44481145cd after 3 cycles, then 67 mode-11 cycles → dout emits the word LSB first (1,0,1,1,0,0,1,1,…), then zeros. mem_re asserted exactly one cycle.
- Busy refusal: core_busy=1 with write req → no mem_we/mem_re, err=1 and held after core_busy drops. A subsequent legal write succeeds with err still 1.
- Reset mid-read: rst=0 in RD_WAIT, then mem_rvalid arrives → ignored. All outputs 0, state IDLE, dout=0.
- Preemption: new read req at address 5 after 20 bits shifted out → remaining bits abandoned; dout follows the new word from bit 0.
